fifo_sync: RTL
==============

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width in bits of one stored word.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the storage depth to DEPTH = 2^ADDR_WIDTH words.
REQ-003 Parameter AFULL_LVL, default DEPTH-2, SHALL set the almost_full threshold.
REQ-004 Parameter AEMPTY_LVL, default 2, SHALL set the almost_empty threshold.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-007 Port wr_en, input, 1 bit: write request.
REQ-008 Port din, input, DATA_WIDTH bits: write data.
REQ-009 Port rd_en, input, 1 bit: read request.
REQ-010 Port dout, output, DATA_WIDTH bits: registered read data.
REQ-011 Port dout_valid, output, 1 bit: dout holds a word popped on the previous edge.
REQ-012 Port full and port empty, outputs, 1 bit each: occupancy equals DEPTH, and occupancy equals 0.
REQ-013 Port almost_full and port almost_empty, outputs, 1 bit each: occupancy >= AFULL_LVL, and occupancy <= AEMPTY_LVL.
REQ-014 Port count, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-015 Port overflow and port underflow, outputs, 1 bit each: one-cycle error pulses.

Function
REQ-016 Write and read pointers SHALL be ADDR_WIDTH+1 bits wide; the low ADDR_WIDTH bits SHALL address memory; the MSB SHALL be the wrap bit.
REQ-017 full SHALL be asserted exactly when the pointer low bits are equal and the wrap bits differ; empty SHALL be asserted exactly when the pointers are fully equal.
REQ-018 A write SHALL be accepted when wr_en=1 and (full=0, or a read is accepted in the same cycle); an accepted write stores din at wptr and increments wptr modulo 2^(ADDR_WIDTH+1).
REQ-019 A read SHALL be accepted when rd_en=1 and empty=0; on the next edge dout takes mem[rptr], dout_valid goes to 1 for one cycle, and rptr increments.
REQ-020 Read latency SHALL be one clock: rd_en is sampled at edge N and data is valid after edge N.
REQ-021 There SHALL be no write-to-read bypass: a read requested while empty is rejected even if a write occurs in the same cycle.
REQ-022 Simultaneous accepted read and write SHALL leave count unchanged; otherwise count SHALL move by +1 on a write and by -1 on a read.
REQ-023 Full, empty, almost_full, almost_empty and count SHALL all be registered, or derived only from registered pointers, and SHALL be consistent in every cycle.
REQ-024 overflow SHALL pulse high for one cycle after an edge where wr_en=1 was rejected; memory and wptr SHALL remain unchanged.
REQ-025 underflow SHALL pulse high for one cycle after an edge where rd_en=1 was rejected; rptr and dout SHALL remain unchanged.
REQ-026 dout SHALL hold its last value when no read is accepted.
REQ-027 Pointer wrap-around past DEPTH-1 SHALL be seamless, with no lost or duplicated word.

Reset
REQ-028 Asserting rst at any time SHALL immediately clear both pointers, count, dout, dout_valid, overflow and underflow to 0, set empty=1 and almost_empty=1, and clear full and almost_full to 0.
REQ-029 Memory contents SHALL NOT be cleared by reset; words stored before reset SHALL be unreachable after reset.
REQ-030 The first write accepted after rst deasserts SHALL be the first word read.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-031 Write 0x11, 0x22, 0x33, 0x44, then read 4 times -> dout = 0x11, 0x22, 0x33, 0x44 in order, each with dout_valid=1 one cycle after rd_en; full=1 after the 4th write; empty=1 after the 4th read.
REQ-032 When full, wr_en=1 with data 0x55 and no read -> overflow pulses 1 cycle, count stays 4, and the later read order is unchanged (0x55 never appears).
REQ-033 When full, wr_en=1 and rd_en=1 together -> both are accepted, count stays 4, and 0x55 appears as the 4th word read afterwards.
REQ-034 When empty, rd_en=1 and wr_en=1 with 0x66 together -> underflow pulses, dout_valid=0, count=1; the next read returns 0x66.
REQ-035 Run 10 write/read pairs to force pointer wrap -> data order is intact; almost_full=1 at count 3; almost_empty=1 at count <= 1.
REQ-036 With count=3, assert rst asynchronously mid-cycle -> count=0, empty=1 and dout=0 before the next edge; after reset, write 0x77 then read -> 0x77.

Source files
------------

// File: rtl/fifo_sync.sv
// fifo_sync -- single-clock FIFO with registered read data.
//
// Storage is 2^ADDR_WIDTH words of DATA_WIDTH bits. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter;
// occupancy and all status flags are derived from the registered pointers.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   wr_en, din   write request and write data
//   rd_en        read request
//   dout         registered read data, holds its value between reads
//   dout_valid   dout carries a word popped on the previous edge
//   full, empty  occupancy == DEPTH, occupancy == 0
//   almost_full  occupancy >= AFULL_LVL
//   almost_empty occupancy <= AEMPTY_LVL
//   count        occupancy, 0..DEPTH
//   overflow     one-cycle pulse after a rejected write
//   underflow    one-cycle pulse after a rejected read
//
// Handshake: a write is accepted on an edge where wr_en=1 and the FIFO is not
// full, or is full but a read is accepted on that same edge. A read is
// accepted on an edge where rd_en=1 and the FIFO is not empty; its data
// appears on dout with dout_valid=1 right after that edge. A read while empty
// is rejected even if a write lands on the same edge (no bypass).

module fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_LVL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_LVL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status, all combinational from the registered pointers so they agree
    // with each other in every cycle and clear the instant rst rises.
    assign empty        = (wptr == rptr);
    assign full         = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                          (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    // Modular difference of the wrap-extended pointers is the occupancy.
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign rd_acc = rd_en && !empty;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign wr_acc = wr_en && (!full || rd_acc);

    // Memory has no reset; stale words become unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                dout <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr <= rptr + 1'b1;
            end
            dout_valid <= rd_acc;
            overflow   <= wr_en && !wr_acc;
            underflow  <= rd_en && !rd_acc;
        end
    end

endmodule
